// File: rtl/m_axi_reg_pkg.sv
// Shared types and AXI constants for the register-bank sequencer.
package m_axi_reg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [3:0] AXI_ID    = 4'h0;
    localparam logic [3:0] WSTRB_ALL = 4'hF;

endpackage

// File: rtl/m_axi_phase_timer.sv
// Per-phase watchdog: counts cycles since the last restart and saturates
// at LIMIT, flagging expiry while saturated.
module m_axi_phase_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic areset,
    input  logic restart,
    output logic expired
);

    localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(LIMIT));

    // Restart wins; otherwise count up and hold at the limit.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset)      cnt <= '0;
        else if (restart) cnt <= '0;
        else if (!expired) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/m_axi_reg_seq.sv
// AXI master sequencer: writes a counter pattern into the downstream
// register bank one transaction at a time, reads back the bank's XOR
// register and compares it with a locally accumulated XOR.
module m_axi_reg_seq
    import m_axi_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_WORDS  = 8,
    parameter int CRC_ADDR   = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] crc_o,
    output logic                  match_o,
    output logic                  err_o,
    output logic [3:0]            awid_o,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [3:0]            wid_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [3:0]            wstrb_o,
    output logic                  wlast_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [3:0]            bid_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    output logic [3:0]            arid_o,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [3:0]            rid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] seed_q, acc_q, crc_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  awvalid_q, wvalid_q, arvalid_q;
    logic                  aw_done_q, w_done_q;
    logic                  err_q, match_q;
    logic                  aw_hs, w_hs, ar_hs, wr_fire, idx_last;
    logic                  abort, expired;

    // IDs, response IDs and rlast carry no information for a single-beat,
    // single-ID master.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, bid_i, rid_i, rlast_i};

    assign aw_hs    = awvalid_q && awready_i;
    assign w_hs     = wvalid_q && wready_i;
    assign ar_hs    = arvalid_q && arready_i;
    assign wr_fire  = (aw_done_q || aw_hs) && (w_done_q || w_hs);
    assign idx_last = (idx_q == ADDR_WIDTH'(NUM_WORDS - 1));

    m_axi_phase_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk     (clk),
        .areset  (areset),
        .restart (state_d != state_q),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state; phase completion takes precedence over a coincident expiry.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            S_IDLE:         if (start_i) state_d = S_WR_ADDR_DATA;
            S_WR_ADDR_DATA: if (wr_fire) state_d = S_WR_RESP;
                            else if (expired) begin state_d = S_DONE; abort = 1'b1; end
            S_WR_RESP:      if (bvalid_i) state_d = idx_last ? S_RD_ADDR : S_WR_ADDR_DATA;
                            else if (expired) begin state_d = S_DONE; abort = 1'b1; end
            S_RD_ADDR:      if (ar_hs) state_d = S_RD_DATA;
                            else if (expired) begin state_d = S_DONE; abort = 1'b1; end
            S_RD_DATA:      if (rvalid_i) state_d = S_DONE;
                            else if (expired) begin state_d = S_DONE; abort = 1'b1; end
            S_DONE:         state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Datapath: valids, write index, XOR accumulator and run status.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            seed_q    <= '0;
            acc_q     <= '0;
            crc_q     <= '0;
            idx_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            if (abort) begin
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                arvalid_q <= 1'b0;
                err_q     <= 1'b1;
                match_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start_i) begin
                        seed_q    <= seed_i;
                        idx_q     <= '0;
                        acc_q     <= '0;
                        err_q     <= 1'b0;
                        match_q   <= 1'b0;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                    S_WR_ADDR_DATA: begin
                        if (aw_hs) begin awvalid_q <= 1'b0; aw_done_q <= 1'b1; end
                        if (w_hs)  begin wvalid_q  <= 1'b0; w_done_q  <= 1'b1; end
                        if (wr_fire) acc_q <= acc_q ^ wdata_o;
                    end
                    S_WR_RESP: if (bvalid_i) begin
                        if (bresp_i != RESP_OKAY) err_q <= 1'b1;
                        idx_q <= idx_q + 1'b1;
                        if (idx_last) begin
                            arvalid_q <= 1'b1;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end
                    end
                    S_RD_ADDR: if (ar_hs) arvalid_q <= 1'b0;
                    S_RD_DATA: if (rvalid_i) begin
                        crc_q   <= rdata_i;
                        match_q <= (rdata_i == acc_q);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign crc_o     = crc_q;
    assign match_o   = match_q;
    assign err_o     = err_q;

    assign awid_o    = AXI_ID;
    assign awaddr_o  = idx_q;
    assign awvalid_o = awvalid_q;
    assign wid_o     = AXI_ID;
    assign wdata_o   = seed_q + DATA_WIDTH'(idx_q);
    assign wstrb_o   = WSTRB_ALL;
    assign wlast_o   = 1'b1;
    assign wvalid_o  = wvalid_q;
    assign bready_o  = (state_q == S_WR_RESP);
    assign arid_o    = AXI_ID;
    assign araddr_o  = (state_q == S_RD_ADDR) ? ADDR_WIDTH'(CRC_ADDR) : '0;
    assign arvalid_o = arvalid_q;
    assign rready_o  = (state_q == S_RD_DATA);

endmodule

// File: tb/tb_m_axi_reg_seq.sv
// Randomized bench: a behavioural register-bank slave with programmable
// handshake delays, protocol monitors, and a run-level expectation model.
module tb_m_axi_reg_seq;

    localparam int DW = 32, AW = 32, NW = 8, CA = 8, TO = 255;

    logic          clk = 1'b0, areset = 1'b0;
    logic          start_i = 1'b0;
    logic [DW-1:0] seed_i = '0;
    logic          busy_o, done_o, match_o, err_o;
    logic [DW-1:0] crc_o, wdata_o, rdata_i;
    logic [3:0]    awid_o, wid_o, arid_o, wstrb_o, bid_i, rid_i;
    logic [AW-1:0] awaddr_o, araddr_o;
    logic          awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
    logic [1:0]    bresp_i;
    logic          bvalid_i, bready_o, arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;

    m_axi_reg_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW),
                    .CRC_ADDR(CA), .TIMEOUT(TO)) dut (
        .clk(clk), .areset(areset), .start_i(start_i), .seed_i(seed_i),
        .busy_o(busy_o), .done_o(done_o), .crc_o(crc_o), .match_o(match_o), .err_o(err_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
        .rready_o(rready_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave knobs
    bit          rnd = 0;
    int          dmax = 0;
    int          aw_fix = 0, w_fix = 0, b_fix = 0, ar_fix = 0, r_fix = 0;
    bit          ar_en = 1;
    bit          rd_ovr = 0;
    logic [31:0] rd_ovr_val = '0;
    int          bad_idx = -1;
    logic [31:0] cur_seed = '0;

    // Slave state
    logic [31:0] regs [CA];
    bit          aw_have, w_have, b_pend, ar_have;
    logic [31:0] aw_addr, w_data, aw_prev, w_prev;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    int          wr_count;
    bit          aw_hold, w_hold, ar_hold, aw_fired, w_fired, ar_fired;

    function automatic int pick(input int fix);
        return rnd ? int'($urandom_range(0, dmax)) : fix;
    endfunction

    function automatic logic [31:0] reg_xor();
        logic [31:0] x = '0;
        for (int i = 0; i < CA; i++) x ^= regs[i];
        return x;
    endfunction

    task automatic new_delays();
        aw_dly = pick(aw_fix); w_dly = pick(w_fix); b_dly = pick(b_fix);
        ar_dly = pick(ar_fix); r_dly = pick(r_fix);
    endtask

    // Behavioural slave and protocol monitor; drives all slave inputs at negedge.
    always @(negedge clk) begin
        if (!areset) begin
            awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0; bid_i = 0;
            arready_i = 0; rvalid_i = 0; rdata_i = 0; rid_i = 0; rlast_i = 0;
            aw_have = 0; w_have = 0; b_pend = 0; ar_have = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_hold = 0; w_hold = 0; ar_hold = 0; aw_fired = 0; w_fired = 0; ar_fired = 0;
            wr_count = 0;
            for (int i = 0; i < CA; i++) regs[i] = '0;
        end else begin
            // Pending valids must hold with a stable payload (aborts land in DONE)
            if (aw_hold && !done_o) chk("aw_stable", {awvalid_o, awaddr_o}, {1'b1, aw_prev});
            if (w_hold && !done_o)  chk("w_stable", {wvalid_o, wdata_o}, {1'b1, w_prev});
            if (ar_hold && !done_o) chk("ar_stable", {arvalid_o, araddr_o}, {1'b1, 32'(CA)});
            if (aw_fired) chk("aw_drop", awvalid_o, 1'b0);
            if (w_fired)  chk("w_drop", wvalid_o, 1'b0);
            if (ar_fired) chk("ar_drop", arvalid_o, 1'b0);

            // Write response follows completion of both write handshakes
            bvalid_i = 0; bresp_i = 0;
            if (aw_have && w_have && !b_pend) begin
                chk("wr_addr", aw_addr, 32'(wr_count));
                chk("wr_data", w_data, cur_seed + 32'(wr_count));
                if (aw_addr < CA) regs[aw_addr] = w_data;
                b_pend = 1; b_cnt = 0;
            end
            if (b_pend) begin
                if (b_cnt >= b_dly) begin
                    bvalid_i = 1;
                    bresp_i  = (wr_count == bad_idx) ? 2'b10 : 2'b00;
                    if (bready_o) begin
                        b_pend = 0; aw_have = 0; w_have = 0; wr_count++;
                        aw_cnt = 0; w_cnt = 0; new_delays();
                    end
                end else b_cnt++;
            end

            // Read data follows the address handshake
            rvalid_i = 0; rdata_i = 0;
            if (ar_have) begin
                if (r_cnt >= r_dly) begin
                    rvalid_i = 1;
                    rdata_i  = rd_ovr ? rd_ovr_val : reg_xor();
                    if (rready_o) begin ar_have = 0; r_cnt = 0; end
                end else r_cnt++;
            end

            arready_i = 0;
            if (arvalid_o && !ar_have && ar_en) begin
                if (ar_cnt >= ar_dly) begin
                    arready_i = 1; ar_have = 1; ar_cnt = 0;
                end else ar_cnt++;
            end

            awready_i = 0;
            if (awvalid_o && !aw_have) begin
                if (aw_cnt >= aw_dly) begin awready_i = 1; aw_have = 1; aw_addr = awaddr_o; end
                else aw_cnt++;
            end
            wready_i = 0;
            if (wvalid_o && !w_have) begin
                if (w_cnt >= w_dly) begin wready_i = 1; w_have = 1; w_data = wdata_o; end
                else w_cnt++;
            end

            aw_hold = awvalid_o && !awready_i; aw_prev = awaddr_o;
            w_hold  = wvalid_o && !wready_i;   w_prev  = wdata_o;
            ar_hold = arvalid_o && !arready_i;
            aw_fired = awvalid_o && awready_i;
            w_fired  = wvalid_o && wready_i;
            ar_fired = arvalid_o && arready_i;
        end
    end

    // One full run from start pulse to done, checked against the run model.
    task automatic do_run(input logic [31:0] seed, input bit exp_to, input string nm);
        logic [31:0] acc, exp_crc;
        bit          seen, exp_err;
        acc = '0;
        for (int i = 0; i < NW; i++) acc ^= seed + 32'(i);
        // Every run rewrites all CA registers (NW == CA), so the bank XOR is acc.
        exp_crc = rd_ovr ? rd_ovr_val : acc;
        exp_err = exp_to || (bad_idx >= 0 && bad_idx < NW);
        new_delays();
        @(negedge clk);
        cur_seed = seed; wr_count = 0;
        start_i = 1; seed_i = seed;
        @(negedge clk);
        start_i = 0; seed_i = $urandom;
        chk({nm, "_first_aw"}, {busy_o, awvalid_o, wvalid_o, awaddr_o}, {3'b111, 32'h0});
        // A start while busy must be ignored
        repeat (2) @(negedge clk);
        start_i = 1;
        @(negedge clk);
        start_i = 0;
        seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            if (done_o) seen = 1;
            else @(negedge clk);
        end
        chk({nm, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({nm, "_err"}, 64'(err_o), 64'(exp_err));
            chk({nm, "_match"}, 64'(match_o), exp_to ? 64'd0 : 64'(exp_crc == acc));
            if (!exp_to) chk({nm, "_crc"}, crc_o, exp_crc);
            chk({nm, "_writes"}, 64'(wr_count), 64'(NW));
            chk({nm, "_valids_at_done"}, {awvalid_o, wvalid_o, arvalid_o}, 3'b000);
            @(negedge clk);
            chk({nm, "_done_pulse"}, {done_o, busy_o}, 2'b00);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy_o, done_o, err_o, match_o}, 4'b0000);
        chk("rst_valid", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o}, 5'b0);
        chk("rst_const", {wstrb_o, wlast_o, awid_o, wid_o, arid_o}, {4'hF, 1'b1, 12'h0});
        chk("rst_data", {awaddr_o, wdata_o}, 64'h0);
        chk("rst_crc", {araddr_o, crc_o}, 64'h0);
        areset = 1;

        // Basic run against a freshly reset bank
        do_run(32'h3, 0, "basic");

        // Address channel stalled while data is accepted at once
        aw_fix = 5; w_fix = 0;
        do_run($urandom, 0, "aw_stall");
        aw_fix = 0;

        // Error response on the third write
        bad_idx = 2;
        do_run($urandom, 0, "bresp");
        bad_idx = -1;

        // Read address never accepted
        ar_en = 0;
        do_run($urandom, 1, "ar_timeout");
        ar_en = 1;

        // Corrupted readback
        rd_ovr = 1; rd_ovr_val = 32'hDEADBEEF;
        do_run($urandom, 0, "bad_crc");
        rd_ovr = 0;

        // Reset during the write-response wait
        b_fix = 30; new_delays();
        @(negedge clk);
        cur_seed = 32'h55; wr_count = 0;
        start_i = 1; seed_i = 32'h55;
        @(negedge clk);
        start_i = 0;
        begin
            bit hit = 0;
            for (int c = 0; c < 200 && !hit; c++) begin
                if (bready_o) hit = 1; else @(negedge clk);
            end
            chk("rst_mid_reach", 64'(hit), 64'd1);
        end
        #2 areset = 0;
        #1 chk("rst_mid_valids", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, busy_o}, 6'b0);
        @(negedge clk);
        #2 areset = 1;
        b_fix = 0;
        do_run($urandom, 0, "after_rst");

        // Randomized handshake timing
        rnd = 1; dmax = 6;
        for (int k = 0; k < 6; k++) do_run($urandom, 0, $sformatf("rnd%0d", k));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
